fetch_controller: RTL
=====================

Name: fetch_controller

Overview:
Instruction-fetch sequencer for the RISC-V core. It owns the program counter and drives the asynchronous instruction ROM (READ_EN, INS_ADDRESS), capturing INSTRUCTION_IN in the same cycle. It presents instructions to decode through a one-entry valid/ready output slot, and handles branch redirects and fetch faults.

Parameters:
TAM_POSICIONES, 1024, number of 32-bit words in the instruction ROM
TAM_PALABRA, 32, instruction width in bits
RESET_PC, 32'h0000_0000, byte address of the first fetch after reset

Ports:
CLK  in  1  clock, rising edge
RST_N  in  1  asynchronous active-low reset
ENABLE  in  1  1 = fetch may run; 0 = stop issuing new fetches
READ_EN  out  1  ROM read enable
INS_ADDRESS  out  $clog2(TAM_POSICIONES)  ROM word address, equal to PC[$clog2(TAM_POSICIONES)+1:2]
INSTRUCTION_IN  in  TAM_PALABRA  ROM data, combinational from INS_ADDRESS
INSTR_OUT  out  TAM_PALABRA  instruction held in the output slot
PC_OUT  out  32  byte address of INSTR_OUT
VALID_OUT  out  1  output slot holds a valid instruction
READY_IN  in  1  decode accepts INSTR_OUT this cycle
BRANCH_EN  in  1  redirect request, one cycle
BRANCH_TARGET  in  32  redirect byte address
FAULT_OUT  out  1  sticky fetch fault

Behaviour:
- Reset (RST_N=0, asynchronous): state=IDLE, PC=RESET_PC, VALID_OUT=0, INSTR_OUT=0, PC_OUT=0, FAULT_OUT=0. READ_EN=0 while in reset.
- States:
  - IDLE. ENABLE=1 -> RUN on the next edge. No loads occur in IDLE.
  - RUN. ENABLE=0 -> IDLE; an instruction already in the slot is kept until it is consumed.
  - FAULT. Terminal state; left only by reset.
- Load condition: state==RUN && !BRANCH_EN && (!VALID_OUT || READY_IN) && PC in range.
  - READ_EN=1 combinationally in the load cycle; otherwise READ_EN=0.
  - At the edge: INSTR_OUT<=INSTRUCTION_IN, PC_OUT<=PC, VALID_OUT<=1, PC<=PC+4.
- Throughput and latency:
  - One instruction per cycle while READY_IN=1.
  - First VALID_OUT is asserted 2 edges after ENABLE is sampled high in IDLE.
- Handshake:
  - A transfer occurs when VALID_OUT && READY_IN.
  - VALID_OUT=1 with READY_IN=0: INSTR_OUT and PC_OUT are held stable and no load occurs.
  - VALID_OUT drops without a transfer only on branch flush, fault, or reset.
  - A transfer with no simultaneous load clears VALID_OUT.
- Branch (BRANCH_EN=1, any state except FAULT; ignored in FAULT):
  - Highest priority. At the edge: PC<=BRANCH_TARGET and VALID_OUT<=0 (flush). No load occurs that cycle.
  - If VALID_OUT && READY_IN in the same cycle, the transfer still counts as done.
  - The target is fetched on the next RUN cycle, giving a 1-cycle bubble.
  - A branch in IDLE updates PC only.
- Fault conditions:
  - BRANCH_TARGET[1:0]!=0.
  - BRANCH_TARGET[31:2] >= TAM_POSICIONES.
  - In RUN, a load would otherwise occur with PC[31:2] >= TAM_POSICIONES (sequential overrun). The last in-range word is delivered normally first.
- Fault action:
  - Next edge: state=FAULT, FAULT_OUT=1, VALID_OUT=0, READ_EN=0.
  - PC holds the offending address for debug.
- PC arithmetic: 32-bit, wraps modulo 2^32. The range check catches the overrun before any ROM access.
- ENABLE falling while a load condition holds: the load in that same cycle completes; no load occurs afterwards.

Decomposition:
- Package fetch_pkg:
  - typedef enum logic [1:0] {IDLE, RUN, FAULT} fetch_state_t
  - constant INSTR_WORD_BYTES = 4
  - localparam function for the ROM address width
- Sub-module fetch_slot: the one-entry valid/ready output register (load, flush, hold). Everything else lives in fetch_controller.

Test Plan:
1. Reset, ENABLE=1, READY_IN=1, ROM[0..3]=A,B,C,D -> VALID_OUT rises 2 edges after ENABLE; then A/0, B/4, C/8, D/12 on consecutive cycles; READ_EN=1 each load cycle.
2. READY_IN=0 for 3 cycles while B/4 is valid -> INSTR_OUT=B, PC_OUT=4 held; READ_EN=0; after READY_IN=1, next value is C/8 with no skip or duplicate.
3. BRANCH_EN with target 0x40 while VALID_OUT=1, READY_IN=0 -> VALID_OUT=0 next edge; ROM[16] appears with PC_OUT=0x40 one cycle later; the flushed instruction is never accepted.
4. BRANCH_EN with target 0x42, then separately with target 4*TAM_POSICIONES -> FAULT_OUT=1, VALID_OUT=0, READ_EN stays 0; further BRANCH_EN and ENABLE have no effect until RST_N.
5. Free-run to the last word 4*(TAM_POSICIONES-1) -> that word is delivered, then FAULT_OUT=1 with PC=4*TAM_POSICIONES.
6. Async reset asserted mid-stream between edges -> outputs clear immediately; after release with ENABLE=1, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
// No timing of its own; no backpressure.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } fetch_state_t;

    localparam int INSTR_WORD_BYTES = 4;

    function automatic int rom_addr_w(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/fetch_slot.sv
// One-entry valid/ready output register; load lands one edge after the request.
// Holds data while valid && !ready; flush wins over load and transfer.
module fetch_slot #(
    parameter int W = 32
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_load,
    input  logic         i_flush,
    input  logic         i_ready,
    input  logic [W-1:0] i_instr,
    input  logic [31:0]  i_pc,
    output logic         o_valid,
    output logic [W-1:0] o_instr,
    output logic [31:0]  o_pc
);

    logic         r_valid;
    logic [W-1:0] r_instr;
    logic [31:0]  r_pc;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid <= 1'b0;
            r_instr <= '0;
            r_pc    <= '0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_instr <= i_instr;
            r_pc    <= i_pc;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_instr = r_instr;
    assign o_pc    = r_pc;

endmodule

// File: rtl/fetch_controller.sv
// Instruction-fetch sequencer: PC owner, async ROM read, first instruction 2 edges after ENABLE.
// Output slot stalls fetch while VALID_OUT && !READY_IN; branches flush and redirect.
module fetch_controller
    import fetch_pkg::*;
#(
    parameter int          TAM_POSICIONES = 1024,
    parameter int          TAM_PALABRA    = 32,
    parameter logic [31:0] RESET_PC       = 32'h0000_0000
) (
    input  logic                                   CLK,
    input  logic                                   RST_N,
    input  logic                                   ENABLE,
    output logic                                   READ_EN,
    output logic [rom_addr_w(TAM_POSICIONES)-1:0]  INS_ADDRESS,
    input  logic [TAM_PALABRA-1:0]                 INSTRUCTION_IN,
    output logic [TAM_PALABRA-1:0]                 INSTR_OUT,
    output logic [31:0]                            PC_OUT,
    output logic                                   VALID_OUT,
    input  logic                                   READY_IN,
    input  logic                                   BRANCH_EN,
    input  logic [31:0]                            BRANCH_TARGET,
    output logic                                   FAULT_OUT
);

    localparam int          AW        = rom_addr_w(TAM_POSICIONES);
    localparam logic [31:0] ROM_WORDS = 32'(TAM_POSICIONES);

    fetch_state_t r_state, w_state_nxt;
    logic [31:0]  r_pc, w_pc_nxt;
    logic         w_load, w_flush, w_pc_in_range, w_tgt_bad, w_slot_free;

    assign w_pc_in_range = {2'b00, r_pc[31:2]} < ROM_WORDS;
    assign w_tgt_bad     = (BRANCH_TARGET[1:0] != 2'b00) ||
                           ({2'b00, BRANCH_TARGET[31:2]} >= ROM_WORDS);
    assign w_slot_free   = !VALID_OUT || READY_IN;

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_load      = 1'b0;
        w_flush     = 1'b0;
        case (r_state)
            IDLE: begin
                if (ENABLE) w_state_nxt = RUN;
                if (BRANCH_EN) begin
                    // A good target in IDLE only moves the PC; the slot is left alone.
                    w_pc_nxt = BRANCH_TARGET;
                    if (w_tgt_bad) begin
                        w_state_nxt = FAULT;
                        w_flush     = 1'b1;
                    end
                end
            end
            RUN: begin
                if (!ENABLE) w_state_nxt = IDLE;
                if (BRANCH_EN) begin
                    w_pc_nxt = BRANCH_TARGET;
                    w_flush  = 1'b1;
                    if (w_tgt_bad) w_state_nxt = FAULT;
                end else if (w_slot_free) begin
                    if (w_pc_in_range) begin
                        w_load   = 1'b1;
                        w_pc_nxt = r_pc + 32'(INSTR_WORD_BYTES);
                    end else begin
                        w_state_nxt = FAULT;
                        w_flush     = 1'b1;
                    end
                end
            end
            FAULT: ;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= IDLE;
            r_pc    <= RESET_PC;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
        end
    end

    fetch_slot #(.W(TAM_PALABRA)) u_slot (
        .i_clk   (CLK),
        .i_rst_n (RST_N),
        .i_load  (w_load),
        .i_flush (w_flush),
        .i_ready (READY_IN),
        .i_instr (INSTRUCTION_IN),
        .i_pc    (r_pc),
        .o_valid (VALID_OUT),
        .o_instr (INSTR_OUT),
        .o_pc    (PC_OUT)
    );

    assign READ_EN     = w_load;
    assign INS_ADDRESS = r_pc[AW+1:2];
    assign FAULT_OUT   = (r_state == FAULT);

endmodule
